// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package im_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int CNT_W   = 16;
    localparam int INSTR_W = 17;

    localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        B0,
        B1,
        B2,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/im_loader_timer.sv
// Inter-byte idle counter: expired flags the TIMEOUT-th consecutive idle cycle.
module im_loader_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A clearing byte always beats expiry in the same cycle.
    assign expired = en && !clr && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/im_prog_loader.sv
// Runtime program download: parses a UART byte stream and drives the IM write port.
module im_prog_loader
    import im_loader_pkg::*;
#(
    parameter int                DEPTH    = 2048,
    parameter int                AW       = 16,
    parameter int                IW       = INSTR_W,
    parameter logic [BYTE_W-1:0] HDR      = HDR_BYTE,
    parameter int                TIMEOUT  = 50000,
    parameter bit                HOLD_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_rdy,
    output logic              im_we,
    output logic [AW-1:0]     im_waddr,
    output logic [IW-1:0]     im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [AW-1:0]     words_loaded
);

    state_t             state;
    logic [BYTE_W-1:0]  chk;
    logic [BYTE_W-1:0]  cnt_hi;
    logic [CNT_W-1:0]   word_count;
    logic [CNT_W-1:0]   word_idx;
    logic               b0_bit;
    logic [BYTE_W-1:0]  b1_byte;

    logic               in_packet;
    logic               expired;
    logic [CNT_W-1:0]   count_rx;
    logic [CNT_W-1:0]   next_idx;

    assign in_packet = !(state inside {IDLE, DONE, ERR});
    assign count_rx  = {cnt_hi, rx_data};
    assign next_idx  = word_idx + 1'b1;

    im_loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_rdy || !in_packet),
        .en      (in_packet),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            im_we        <= 1'b0;
            im_waddr     <= '0;
            im_wdata     <= '0;
            cpu_hold     <= HOLD_RST;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            chk          <= '0;
            cnt_hi       <= '0;
            word_count   <= '0;
            word_idx     <= '0;
            b0_bit       <= 1'b0;
            b1_byte      <= '0;
        end else begin
            // Write enable is a one-cycle pulse; only the B2 branch raises it.
            im_we <= 1'b0;
            if (rx_rdy) begin
                case (state)
                    IDLE, DONE, ERR: begin
                        if (rx_data == HDR) begin
                            state        <= CNT_HI;
                            cpu_hold     <= 1'b1;
                            load_done    <= 1'b0;
                            load_err     <= 1'b0;
                            words_loaded <= '0;
                            chk          <= '0;
                            word_idx     <= '0;
                        end
                    end
                    CNT_HI: begin
                        cnt_hi <= rx_data;
                        chk    <= chk ^ rx_data;
                        state  <= CNT_LO;
                    end
                    CNT_LO: begin
                        word_count <= count_rx;
                        chk        <= chk ^ rx_data;
                        if (count_rx > CNT_W'(DEPTH)) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else if (count_rx == '0) begin
                            state <= CHK;
                        end else begin
                            state <= B0;
                        end
                    end
                    B0: begin
                        chk <= chk ^ rx_data;
                        if (rx_data[BYTE_W-1:1] != '0) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else begin
                            b0_bit <= rx_data[0];
                            state  <= B1;
                        end
                    end
                    B1: begin
                        b1_byte <= rx_data;
                        chk     <= chk ^ rx_data;
                        state   <= B2;
                    end
                    B2: begin
                        im_wdata     <= IW'({b0_bit, b1_byte, rx_data});
                        im_waddr     <= AW'(word_idx);
                        im_we        <= 1'b1;
                        words_loaded <= words_loaded + 1'b1;
                        word_idx     <= next_idx;
                        chk          <= chk ^ rx_data;
                        state        <= (next_idx == word_count) ? CHK : B0;
                    end
                    CHK: begin
                        if (rx_data == chk) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (expired) begin
                state    <= ERR;
                load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_im_prog_loader.sv
// Directed bench for im_prog_loader: expected IM writes go to a scoreboard queue.
module tb_im_prog_loader;
    import im_loader_pkg::*;

    localparam int TO = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [16:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        im_we;
    logic [15:0] im_waddr;
    logic [16:0] im_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    wr_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  run_chk;

    im_prog_loader #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .im_we        (im_we),
        .im_waddr     (im_waddr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (im_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             im_waddr, im_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(im_waddr), 32'(e.addr));
                    check("write_data", 32'(im_wdata), 32'(e.data));
                end
            end
        end
    end

    // One strobe, then one idle cycle; returns #1 after the second edge.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(posedge clk); #1;
        rx_rdy  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic sendc(input logic [7:0] b);
        run_chk = run_chk ^ b;
        send(b);
    endtask

    task automatic send_word(input logic [15:0] idx, input logic [16:0] w);
        sendc({7'b0, w[16]});
        sendc(w[15:8]);
        exp_q.push_back('{addr: idx, data: w});
        sendc(w[7:0]);
    endtask

    task automatic send_body(input logic [16:0] w[$]);
        logic [15:0] n;
        n       = 16'(w.size());
        run_chk = 8'h00;
        send(HDR_BYTE);
        sendc(n[15:8]);
        sendc(n[7:0]);
        foreach (w[i]) send_word(16'(i), w[i]);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic hold, input logic [15:0] wl);
        check({tag, "_load_done"}, 32'(load_done), 32'(done));
        check({tag, "_load_err"}, 32'(load_err), 32'(err));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(wl));
    endtask

    initial begin
        logic [16:0] two_words[$];
        logic [16:0] one_word[$];
        logic [16:0] no_words[$];
        two_words = '{17'h12345, 17'h0ABCD};
        one_word  = '{17'h12345};
        no_words  = {};

        rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0;
        #2;
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_waddr", 32'(im_waddr), 32'd0);
        check("rst_im_wdata", 32'(im_wdata), 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: two words, correct checksum (XOR of 00 02 01 23 45 00 AB CD = 0x03)
        send_body(two_words);
        check("t1_hold_while_loading", 32'(cpu_hold), 32'd1);
        send(8'h03);
        check_status("t1", 1'b1, 1'b0, 1'b0, 16'd2);

        // 2: same packet, wrong checksum
        send_body(two_words);
        send(8'h00);
        check_status("t2", 1'b0, 1'b1, 1'b1, 16'd2);

        // 3: N=2049 rejected straight after the count, then an empty packet
        send(HDR_BYTE); send(8'h08); send(8'h01);
        check_status("t3_oversize", 1'b0, 1'b1, 1'b1, 16'd0);
        send_body(no_words);
        send(8'h00);
        check_status("t3_empty", 1'b1, 1'b0, 1'b0, 16'd0);

        // 4a: silence after byte B1; error exactly on the 16th idle edge
        run_chk = 8'h00;
        send(HDR_BYTE); sendc(8'h00); sendc(8'h01); sendc(8'h01);
        rx_data = 8'h23; rx_rdy = 1'b1;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1 check("t4_no_err_before_timeout", 32'(load_err), 32'd0);
        @(posedge clk); #1;
        check_status("t4_timeout", 1'b0, 1'b1, 1'b1, 16'd0);

        // 4b: byte on the 16th idle cycle wins over expiry
        run_chk = 8'h00;
        send(HDR_BYTE); sendc(8'h00); sendc(8'h01); sendc(8'h01);
        rx_data = 8'h23; rx_rdy = 1'b1; run_chk = run_chk ^ 8'h23;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        exp_q.push_back('{addr: 16'd0, data: 17'h12345});
        sendc(8'h45);
        check("t4_boundary_no_err", 32'(load_err), 32'd0);
        send(run_chk);
        check_status("t4_boundary", 1'b1, 1'b0, 1'b0, 16'd1);

        // 5: stray byte ignored while idle, then illegal B0 byte
        send(8'h55);
        check_status("t5_stray", 1'b1, 1'b0, 1'b0, 16'd1);
        send(HDR_BYTE); send(8'h00); send(8'h01); send(8'h02);
        check_status("t5_bad_b0", 1'b0, 1'b1, 1'b1, 16'd0);

        // 6: asynchronous reset while in B1, then a clean reload
        send(HDR_BYTE); send(8'h00); send(8'h01); send(8'h01);
        #3 rst = 1'b1;
        #1;
        check("t6_im_we", 32'(im_we), 32'd0);
        check("t6_im_waddr", 32'(im_waddr), 32'd0);
        check("t6_im_wdata", 32'(im_wdata), 32'd0);
        check_status("t6_rst", 1'b0, 1'b0, 1'b1, 16'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        send_body(one_word);
        send(run_chk);
        check_status("t6_reload", 1'b1, 1'b0, 1'b0, 16'd1);

        repeat (3) @(posedge clk);
        #1 check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
